// File: rtl/seq_detect_pkg.sv
// Shared defaults, width helper and output-mode encoding for the
// parameterised serial pattern detector.
package seq_detect_pkg;

  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_CNT_W   = 8;

  typedef enum logic {
    MODE_MEALY = 1'b0,
    MODE_MOORE = 1'b1
  } mode_e;

  // Bits needed to hold a pattern length in the range 0..max_len.
  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/seq_match_cmp.sv
// Masked compare of the newest cfg_len bits (history plus the incoming bit)
// against the low cfg_len bits of the stored pattern.
module seq_match_cmp
  import seq_detect_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = len_w(MAX_LEN)
) (
  input  logic [MAX_LEN-1:0] hist,
  input  logic               x,
  input  logic [MAX_LEN-1:0] cfg_pat,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [LEN_W-1:0]   fill,
  input  logic               sample,
  output logic               match
);

  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] mask;
  logic [MAX_LEN-1:0] diff;
  logic               len_ok;
  logic               fill_ok;
  logic               unused_hist_msb;

  // The oldest history bit can never fall inside a MAX_LEN-wide window
  // that also contains the incoming bit.
  assign unused_hist_msb = hist[MAX_LEN-1];
  assign window          = {hist[MAX_LEN-2:0], x};

  genvar gi;
  for (gi = 0; gi < MAX_LEN; gi++) begin : g_mask
    assign mask[gi] = (gi < int'(cfg_len));
  end

  assign diff    = (window ^ cfg_pat) & mask;
  assign len_ok  = (cfg_len >= LEN_W'(2));
  assign fill_ok = len_ok && (fill >= (cfg_len - LEN_W'(1)));
  assign match   = sample && fill_ok && (diff == '0);

endmodule

// File: rtl/seq_detect_param.sv
// Runtime-configurable serial sequence detector with selectable Mealy/Moore
// output, optional overlapping matches and a saturating match counter.
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      x,
  input  logic                      x_valid,
  input  logic                      cfg_load,
  input  logic [MAX_LEN-1:0]        pattern,
  input  logic [len_w(MAX_LEN)-1:0] pat_len,
  input  logic                      overlap,
  input  logic                      moore_mode,
  input  logic                      clear_cnt,
  output logic                      y,
  output logic [CNT_W-1:0]          match_count
);

  localparam int               LEN_W     = len_w(MAX_LEN);
  localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic [MAX_LEN-1:0] cfg_pat_q, cfg_pat_d;
  logic [LEN_W-1:0]   cfg_len_q, cfg_len_d;
  logic               cfg_ovl_q, cfg_ovl_d;
  mode_e              cfg_moore_q, cfg_moore_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               y_moore_q, y_moore_d;
  logic               match;

  seq_match_cmp #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_cmp (
    .hist    (hist_q),
    .x       (x),
    .cfg_pat (cfg_pat_q),
    .cfg_len (cfg_len_q),
    .fill    (fill_q),
    .sample  (x_valid && !cfg_load),
    .match   (match)
  );

  always_comb begin
    cfg_pat_d   = cfg_pat_q;
    cfg_len_d   = cfg_len_q;
    cfg_ovl_d   = cfg_ovl_q;
    cfg_moore_d = cfg_moore_q;
    hist_d      = hist_q;
    fill_d      = fill_q;
    y_moore_d   = match;

    if (cfg_load) begin
      cfg_pat_d   = pattern;
      cfg_len_d   = (pat_len > MAX_LEN_V) ? MAX_LEN_V : pat_len;
      cfg_ovl_d   = overlap;
      cfg_moore_d = moore_mode ? MODE_MOORE : MODE_MEALY;
      hist_d      = '0;
      fill_d      = '0;
      y_moore_d   = 1'b0;
    end else if (x_valid) begin
      hist_d = {hist_q[MAX_LEN-2:0], x};
      // Without overlap a match consumes its bits, so the next one needs a full fresh window.
      if (match && !cfg_ovl_q) begin
        fill_d = '0;
      end else if (fill_q != MAX_LEN_V) begin
        fill_d = fill_q + LEN_W'(1);
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clear_cnt) begin
      cnt_d = '0;
    end else if (match && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_pat_q   <= '0;
      cfg_len_q   <= '0;
      cfg_ovl_q   <= 1'b1;
      cfg_moore_q <= MODE_MEALY;
      hist_q      <= '0;
      fill_q      <= '0;
      cnt_q       <= '0;
      y_moore_q   <= 1'b0;
    end else begin
      cfg_pat_q   <= cfg_pat_d;
      cfg_len_q   <= cfg_len_d;
      cfg_ovl_q   <= cfg_ovl_d;
      cfg_moore_q <= cfg_moore_d;
      hist_q      <= hist_d;
      fill_q      <= fill_d;
      cnt_q       <= cnt_d;
      y_moore_q   <= y_moore_d;
    end
  end

  assign y           = (cfg_moore_q == MODE_MOORE) ? y_moore_q : match;
  assign match_count = cnt_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench for seq_detect_param: stimulus queues the expected y and
// match_count for every cycle it drives, a monitor pops and compares them.
module tb_seq_detect_param;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               reset;
  logic               x;
  logic               x_valid;
  logic               cfg_load;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   pat_len;
  logic               overlap;
  logic               moore_mode;
  logic               clear_cnt;
  logic               y;
  logic [CNT_W-1:0]   match_count;

  always #5 clk = ~clk;

  seq_detect_param #(
    .MAX_LEN (MAX_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .x           (x),
    .x_valid     (x_valid),
    .cfg_load    (cfg_load),
    .pattern     (pattern),
    .pat_len     (pat_len),
    .overlap     (overlap),
    .moore_mode  (moore_mode),
    .clear_cnt   (clear_cnt),
    .y           (y),
    .match_count (match_count)
  );

  typedef struct {
    string            name;
    int               idx;
    logic             exp_y;
    logic [CNT_W-1:0] exp_cnt;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference state: count, match of previous cycle, and loaded output mode.
  int   m_cnt   = 0;
  logic m_prev  = 1'b0;
  logic m_moore = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      $display("%s[%0d] y=%0b cnt=%0d", e.name, e.idx, y, match_count);
      checks++;
      if (y !== e.exp_y) begin
        errors++;
        $display("FAIL %s[%0d] y: got %0b required %0b", e.name, e.idx, y, e.exp_y);
      end
      checks++;
      if (match_count !== e.exp_cnt) begin
        errors++;
        $display("FAIL %s[%0d] match_count: got %0d required %0d",
                 e.name, e.idx, match_count, e.exp_cnt);
      end
    end
  end

  task automatic push(input string nm, input int i, input logic ey);
    exp_t e;
    e.name    = nm;
    e.idx     = i;
    e.exp_y   = ey;
    e.exp_cnt = CNT_W'(m_cnt);
    sb.push_back(e);
  endtask

  // One data cycle; live config inputs are scrambled so only latched config matters.
  task automatic step(input string nm, input int i, input logic v, input logic xb,
                      input logic m, input logic clr);
    @(posedge clk);
    #1;
    cfg_load   = 1'b0;
    x_valid    = v;
    x          = xb;
    clear_cnt  = clr;
    pattern    = '0;
    pat_len    = '0;
    overlap    = 1'b0;
    moore_mode = 1'b0;
    push(nm, i, m_moore ? m_prev : m);
    if (clr) m_cnt = 0;
    else if (m && m_cnt < CNT_SAT) m_cnt++;
    m_prev = m;
  endtask

  // bits: '1'/'0' accepted bit, '-' idle cycle. ex: 'M' where a match is expected.
  task automatic run(input string nm, input string bits, input string ex, input logic clr_last);
    for (int i = 0; i < bits.len(); i++) begin
      step(nm, i, bits[i] != "-", bits[i] == "1", ex[i] == "M",
           clr_last && (i == bits.len() - 1));
    end
  endtask

  // x is held valid and high during the load cycle; it must be ignored.
  task automatic load(input string nm, input logic [MAX_LEN-1:0] pat,
                      input logic [LEN_W-1:0] len, input logic ovl, input logic moore);
    @(posedge clk);
    #1;
    cfg_load   = 1'b1;
    x_valid    = 1'b1;
    x          = 1'b1;
    clear_cnt  = 1'b0;
    pattern    = pat;
    pat_len    = len;
    overlap    = ovl;
    moore_mode = moore;
    push(nm, 0, m_moore ? m_prev : 1'b0);
    m_moore = moore;
    m_prev  = 1'b0;
  endtask

  task automatic do_reset(input string nm);
    @(posedge clk);
    #2;
    reset     = 1'b1;
    cfg_load  = 1'b0;
    x_valid   = 1'b0;
    clear_cnt = 1'b0;
    m_cnt     = 0;
    m_prev    = 1'b0;
    m_moore   = 1'b0;
    push(nm, 0, 1'b0);
    #5;
    reset = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    x          = 1'b0;
    x_valid    = 1'b0;
    cfg_load   = 1'b0;
    pattern    = '0;
    pat_len    = '0;
    overlap    = 1'b0;
    moore_mode = 1'b0;
    clear_cnt  = 1'b0;

    do_reset("reset");
    run("disabled_after_reset", "1101", "....", 1'b0);

    load("cfg_ovl", 8'h0D, 4'd4, 1'b1, 1'b0);
    run("mealy_ovl", "1101101", "...M..M", 1'b0);
    run("clear", "-", ".", 1'b1);

    load("cfg_noovl", 8'h0D, 4'd4, 1'b0, 1'b0);
    run("mealy_noovl_a", "1101101", "...M...", 1'b0);
    load("cfg_noovl", 8'h0D, 4'd4, 1'b0, 1'b0);
    run("mealy_noovl_b", "11011101", "...M...M", 1'b0);
    run("clear", "-", ".", 1'b1);

    load("cfg_moore", 8'h0D, 4'd4, 1'b1, 1'b1);
    run("moore_gaps", "1-10--1--", "......M..", 1'b0);
    run("clear", "-", ".", 1'b1);

    load("cfg_len8", 8'hA5, 4'd8, 1'b1, 1'b0);
    run("len8", "0011110010100101", "...............M", 1'b0);
    load("cfg_len9", 8'hA5, 4'd9, 1'b1, 1'b0);
    run("len9_clamped", "0011110010100101", "...............M", 1'b0);
    load("cfg_len1", 8'hA5, 4'd1, 1'b1, 1'b0);
    run("len1_disabled", "0011110010100101", "................", 1'b0);
    run("clear", "-", ".", 1'b1);

    load("cfg_sat", 8'h0D, 4'd4, 1'b1, 1'b0);
    run("saturate", "1101101101101101", "...M..M..M..M..M", 1'b0);
    run("clear_on_match", "101", "..M", 1'b1);
    run("after_clear", "-", ".", 1'b0);

    load("cfg_rst", 8'h0D, 4'd4, 1'b1, 1'b0);
    run("pre_reset", "110", "...", 1'b0);
    do_reset("mid_reset");
    load("cfg_rst", 8'h0D, 4'd4, 1'b1, 1'b0);
    run("post_reset", "1101", "...M", 1'b0);

    load("cfg_mid", 8'h0D, 4'd4, 1'b1, 1'b0);
    run("pre_load", "110", "...", 1'b0);
    load("reload", 8'h0D, 4'd4, 1'b1, 1'b0);
    run("post_load", "1101", "...M", 1'b0);

    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d required=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
